// File: rtl/seq_sub_pkg.sv
// Shared types and constants for the sequential CLA subtractor.
// FSM encoding, default geometry and the counter-width helper.
package seq_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam int unsigned DEF_N     = 32'd64;
    localparam int unsigned DEF_CHUNK = 32'd8;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 32'd0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 32'd1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cla_chunk_adder.sv
// Combinational W-bit carry-lookahead adder: every carry is a flat
// sum-of-products over generate/propagate terms and the carry-in.
module cla_chunk_adder #(
    parameter int unsigned W = 32'd8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W-1:0] gen_s;
    logic [W-1:0] prop_s;
    logic [W:0]   carry_s;
    logic         term_s;
    logic         pchain_s;

    assign gen_s  = x & y;
    assign prop_s = x ^ y;

    // Expand c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin without rippling.
    always_comb begin
        carry_s    = '0;
        term_s     = 1'b0;
        pchain_s   = 1'b0;
        carry_s[0] = cin;
        for (int i = 0; i < int'(W); i++) begin
            term_s   = gen_s[i];
            pchain_s = prop_s[i];
            for (int j = i - 1; j >= 0; j--) begin
                term_s   = term_s | (pchain_s & gen_s[j]);
                pchain_s = pchain_s & prop_s[j];
            end
            carry_s[i+1] = term_s | (pchain_s & cin);
        end
    end

    assign sum  = prop_s ^ carry_s[W-1:0];
    assign cout = carry_s[W];

endmodule

// File: rtl/nbit_seq_cla_subtractor.sv
// Multi-cycle N-bit subtractor (a + ~b + 1), CHUNK bits per clock.
// Optional add/subtract select port enabled by SEQ_SUB_ADD_MODE_EN.
module nbit_seq_cla_subtractor
    import seq_sub_pkg::*;
#(
    parameter int unsigned N     = DEF_N,
    parameter int unsigned CHUNK = DEF_CHUNK
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
`ifdef SEQ_SUB_ADD_MODE_EN
    input  logic         op,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N:0]   result
);

    localparam int unsigned NCH = N / CHUNK;
    localparam int unsigned CW  = (clog2(NCH) > 32'd0) ? clog2(NCH) : 32'd1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NCH - 32'd1);

    if ((N % CHUNK) != 32'd0) begin : g_bad_chunk
        $error("N must be a multiple of CHUNK");
    end

    state_e           state_r;
    state_e           state_nxt_s;
    logic [CW-1:0]    cnt_r;
    logic [N-1:0]     a_sh_r;
    logic [N-1:0]     b_sh_r;
    logic [N-1:0]     acc_r;
    logic             carry_r;
    logic [N:0]       result_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [CHUNK-1:0] sum_s;
    logic             cout_s;
    logic             accept_s;
    logic             last_s;
    logic [N-1:0]     b_load_s;
    logic             carry_load_s;
    logic             flag_s;
    logic [N+CHUNK-1:0] acc_cat_s;

    cla_chunk_adder #(.W(CHUNK)) u_chunk (
        .x    (a_sh_r[CHUNK-1:0]),
        .y    (b_sh_r[CHUNK-1:0]),
        .cin  (carry_r),
        .sum  (sum_s),
        .cout (cout_s)
    );

`ifdef SEQ_SUB_ADD_MODE_EN
    logic op_r;
    assign b_load_s     = op ? b : ~b;
    assign carry_load_s = ~op;
    // Add mode reports the raw carry; subtract reports borrow = ~carry.
    assign flag_s       = op_r ? cout_s : ~cout_s;

    // Latch the operation select alongside the operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r <= 1'b0;
        end else if (accept_s) begin
            op_r <= op;
        end else begin
            op_r <= op_r;
        end
    end
`else
    assign b_load_s     = ~b;
    assign carry_load_s = 1'b1;
    assign flag_s       = ~cout_s;
`endif

    // New chunk enters from the MSB side of the accumulator.
    assign acc_cat_s = {sum_s, acc_r};

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        last_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == LAST_CNT) begin
                    last_s      = 1'b1;
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, handshake flags and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            a_sh_r      <= '0;
            b_sh_r      <= '0;
            acc_r       <= '0;
            carry_r     <= 1'b0;
            result_r    <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == ST_IDLE);
            out_valid_r <= (state_nxt_s == ST_DONE);
            if (accept_s) begin
                a_sh_r  <= a;
                b_sh_r  <= b_load_s;
                carry_r <= carry_load_s;
                cnt_r   <= '0;
            end else if (state_r == ST_RUN) begin
                a_sh_r  <= a_sh_r >> CHUNK;
                b_sh_r  <= b_sh_r >> CHUNK;
                carry_r <= cout_s;
                cnt_r   <= cnt_r + CW'(1);
                acc_r   <= acc_cat_s[N+CHUNK-1:CHUNK];
                // result only changes on the final chunk so it stays stable otherwise.
                if (last_s) begin
                    result_r <= {flag_s, acc_cat_s[N+CHUNK-1:CHUNK]};
                end else begin
                    result_r <= result_r;
                end
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;

endmodule

// File: tb/tb_nbit_seq_cla_subtractor.sv
// Directed bench for nbit_seq_cla_subtractor (N=64, CHUNK=8); the add-mode
// vectors are built only when SEQ_SUB_ADD_MODE_EN is defined.
module tb_nbit_seq_cla_subtractor;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        op;
    logic        out_valid;
    logic        out_ready;
    logic [64:0] result;

    int checks;
    int errors;

    nbit_seq_cla_subtractor #(.N(64), .CHUNK(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef SEQ_SUB_ADD_MODE_EN
        .op        (op),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present operands, wait for acceptance, then for out_valid; checks latency.
    task automatic issue(input logic [63:0] av, input logic [63:0] bv, input logic opv);
        int waitc;
        int lat;
        @(negedge clk);
        waitc = 0;
        while (!in_ready && waitc < 40) begin
            @(negedge clk);
            waitc++;
        end
        in_valid = 1'b1;
        a  = av;
        b  = bv;
        op = opv;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = ~av;
        b = ~bv;
        check_eq("in_ready_low_run", {64'd0, in_ready}, 65'd0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("latency", 65'(lat), 65'd8);
        check_eq("in_ready_low_done", {64'd0, in_ready}, 65'd0);
    endtask

    task automatic drain();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq("out_valid_drop", {64'd0, out_valid}, 65'd0);
        check_eq("in_ready_back", {64'd0, in_ready}, 65'd1);
    endtask

    task automatic run_op(input string tag, input logic [63:0] av, input logic [63:0] bv,
                          input logic opv, input logic [64:0] exp);
        issue(av, bv, opv);
        check_eq(tag, result, exp);
        drain();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = 64'd0;
        b         = 64'd0;
        op        = 1'b0;
        out_ready = 1'b0;
        #23;
        check_eq("rst_in_ready", {64'd0, in_ready}, 65'd1);
        check_eq("rst_out_valid", {64'd0, out_valid}, 65'd0);
        check_eq("rst_result", result, 65'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("t1_5m3", 64'd5, 64'd3, 1'b0, {1'b0, 64'd2});
        run_op("t2_0m1", 64'd0, 64'd1, 1'b0, {1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
        run_op("t3_eq", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 65'd0);
        run_op("t3_b0", 64'h0000_F800_1000_0700, 64'd0, 1'b0, {1'b0, 64'h0000_F800_1000_0700});

        // Backpressure with a competing request that must be ignored.
        issue(64'd100, 64'd58, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a = 64'd7;
            b = 64'd7;
            @(posedge clk);
            #1;
            check_eq("t4_hold_result", result, {1'b0, 64'd42});
            check_eq("t4_hold_valid", {64'd0, out_valid}, 65'd1);
            check_eq("t4_hold_ready", {64'd0, in_ready}, 65'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        drain();
        @(posedge clk);
        #1;
        check_eq("t4_idle_keeps_result", result, {1'b0, 64'd42});
        check_eq("t4_idle_no_start", {64'd0, in_ready}, 65'd1);
        run_op("t4_7m7", 64'd7, 64'd7, 1'b0, 65'd0);

        // Reset in the middle of RUN.
        @(negedge clk);
        in_valid = 1'b1;
        a = 64'd1000;
        b = 64'd1;
        op = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t5_rst_in_ready", {64'd0, in_ready}, 65'd1);
        check_eq("t5_rst_out_valid", {64'd0, out_valid}, 65'd0);
        check_eq("t5_rst_result", result, 65'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("t5_1000m1", 64'd1000, 64'd1, 1'b0, {1'b0, 64'd999});

        run_op("t6_sub", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, {1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
`ifdef SEQ_SUB_ADD_MODE_EN
        run_op("t6_add", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, {1'b1, 64'd0});
        run_op("t6_add_small", 64'd40, 64'd2, 1'b1, {1'b0, 64'd42});
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
